l2_req_arbiter: RTL

//  Shares the single L1->L2 miss/refill port between the icache and the dcache. Round-robin

---
 rtl/kiwi_mem_pkg.sv | 23 ++
 rtl/l2_req_arbiter_rr_arb2.sv | 53 +++++
 rtl/l2_req_arbiter.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/kiwi_mem_pkg.sv
// -----------------------------------------------------------------------------
// kiwi_mem_pkg
//   Shared definitions for the L1->L2 request path: FSM state encoding of the
//   L2 request arbiter, requester identifiers and line geometry.
// -----------------------------------------------------------------------------
package kiwi_mem_pkg;

  // Cache line width in bits and the byte-offset width of a 64-byte line
  localparam int LINE_SIZE    = 512;
  localparam int OFFSET_WIDTH = 6;

  // Requester identifiers (also the bit index in the 2-bit request/grant vectors)
  localparam logic REQ_IC = 1'b0;
  localparam logic REQ_DC = 1'b1;

  // Arbiter FSM states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } arb_state_e;

endpackage : kiwi_mem_pkg

// File: rtl/l2_req_arbiter_rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
//   Two-way round-robin arbiter.
//   Ports:
//     clk, rst_n  clock / async active-low reset
//     req_i[1:0]  request vector (bit 0 = icache, bit 1 = dcache)
//     advance_i   a grant issued this cycle is consumed; move the pointer
//     gnt_o[1:0]  one-hot (or zero) grant, combinational from req_i
//   The pointer names the requester that wins a tie; after reset it favours
//   bit 0 (icache).
// -----------------------------------------------------------------------------
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_i,
  input  logic       advance_i,
  output logic [1:0] gnt_o
);

  logic ptr_q;
  logic ptr_d;
  logic [1:0] gnt;

  // Grant selection and pointer update
  always_comb begin
    gnt   = 2'b00;
    ptr_d = ptr_q;
    case (req_i)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = ptr_q ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
    // After a grant, the tie goes to whoever was not just served
    if (advance_i && (gnt != 2'b00)) begin
      ptr_d = gnt[0];
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Round-robin pointer register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign gnt_o = gnt;

endmodule : rr_arb2

// File: rtl/l2_req_arbiter.sv
// -----------------------------------------------------------------------------
// l2_req_arbiter
//   Shares the single L1->L2 miss/refill port between icache and dcache.
//   Round-robin grant, one outstanding L2 transaction, response steered back
//   to the owner; an owner flushed while its transaction is in flight gets
//   no response valid.
//   Ports:
//     ic_req_*   icache read miss request / ack, ic_resp_* refill, ic_flush_i
//     dc_req_*   dcache refill or writeback request / ack, dc_resp_*, dc_flush_i
//     l2req_*    request towards L2 (held until l2req_ack_i)
//     l2resp_*   L2 response, one per request
//   Upstream acks and response valids are combinational (same-cycle) by
//   design; everything sent to L2 comes from registers.
// -----------------------------------------------------------------------------
module l2_req_arbiter
  import kiwi_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 64,
  parameter int LINE_SIZE  = 512
) (
  input  logic                  clk,
  input  logic                  rst_n,
  // icache
  input  logic                  ic_req_vld_i,
  output logic                  ic_req_ack_o,
  input  logic [ADDR_WIDTH-1:0] ic_req_addr_i,
  output logic                  ic_resp_vld_o,
  output logic [LINE_SIZE-1:0]  ic_resp_data_o,
  input  logic                  ic_flush_i,
  // dcache
  input  logic                  dc_req_vld_i,
  output logic                  dc_req_ack_o,
  input  logic                  dc_req_rd_i,
  input  logic [ADDR_WIDTH-1:0] dc_req_addr_i,
  input  logic [LINE_SIZE-1:0]  dc_req_wdata_i,
  output logic                  dc_resp_vld_o,
  output logic [LINE_SIZE-1:0]  dc_resp_data_o,
  input  logic                  dc_flush_i,
  // L2 side
  output logic                  l2req_vld_o,
  input  logic                  l2req_ack_i,
  output logic                  l2req_rd_o,
  output logic [ADDR_WIDTH-1:0] l2req_addr_o,
  output logic [LINE_SIZE-1:0]  l2req_wdata_o,
  input  logic                  l2resp_vld_i,
  input  logic [LINE_SIZE-1:0]  l2resp_data_i
);

  localparam logic [ADDR_WIDTH-1:0] LINE_MASK =
    {{(ADDR_WIDTH-OFFSET_WIDTH){1'b1}}, {OFFSET_WIDTH{1'b0}}};

  arb_state_e            state_q, state_d;
  logic                  owner_q, owner_d;
  logic                  rd_q, rd_d;
  logic                  drop_q, drop_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LINE_SIZE-1:0]  wdata_q, wdata_d;

  logic [1:0] eligible;
  logic [1:0] arb_req;
  logic [1:0] gnt;
  logic       in_idle;
  logic       owner_flush;
  logic       drop_now;
  logic       ic_ack, dc_ack, ic_rvld, dc_rvld, l2_vld;

  // A requester that is flushing this cycle is not allowed to win
  assign eligible    = {dc_req_vld_i & ~dc_flush_i, ic_req_vld_i & ~ic_flush_i};
  assign in_idle     = (state_q == IDLE);
  assign arb_req     = in_idle ? eligible : 2'b00;
  assign owner_flush = (owner_q == REQ_DC) ? dc_flush_i : ic_flush_i;
  // Flush arriving together with the response still suppresses it
  assign drop_now    = drop_q | owner_flush;

  rr_arb2 u_rr_arb2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_i     (arb_req),
    .advance_i (in_idle),
    .gnt_o     (gnt)
  );

  // FSM next state, latched request fields and upstream/L2 handshakes
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    rd_d    = rd_q;
    drop_d  = drop_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    ic_ack  = 1'b0;
    dc_ack  = 1'b0;
    ic_rvld = 1'b0;
    dc_rvld = 1'b0;
    l2_vld  = 1'b0;
    case (state_q)
      IDLE: begin
        drop_d = 1'b0;
        if (gnt[0]) begin
          ic_ack  = 1'b1;
          owner_d = REQ_IC;
          rd_d    = 1'b1;
          addr_d  = ic_req_addr_i;
          wdata_d = {LINE_SIZE{1'b0}};
          state_d = REQ;
        end else if (gnt[1]) begin
          dc_ack  = 1'b1;
          owner_d = REQ_DC;
          rd_d    = dc_req_rd_i;
          addr_d  = dc_req_addr_i;
          wdata_d = dc_req_wdata_i;
          state_d = REQ;
        end else begin
          state_d = IDLE;
        end
      end
      REQ: begin
        // Request stays up until L2 takes it, flush or not
        l2_vld = 1'b1;
        if (owner_flush) begin
          drop_d = 1'b1;
        end else begin
          drop_d = drop_q;
        end
        if (l2req_ack_i) begin
          state_d = WAIT;
        end else begin
          state_d = REQ;
        end
      end
      WAIT: begin
        if (l2resp_vld_i) begin
          if (!drop_now) begin
            ic_rvld = (owner_q == REQ_IC);
            dc_rvld = (owner_q == REQ_DC);
          end else begin
            ic_rvld = 1'b0;
            dc_rvld = 1'b0;
          end
          drop_d  = 1'b0;
          state_d = IDLE;
        end else begin
          drop_d  = drop_now;
          state_d = WAIT;
        end
      end
      default: begin
        drop_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State and latched transaction registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= REQ_IC;
      rd_q    <= 1'b0;
      drop_q  <= 1'b0;
      addr_q  <= {ADDR_WIDTH{1'b0}};
      wdata_q <= {LINE_SIZE{1'b0}};
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rd_q    <= rd_d;
      drop_q  <= drop_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign ic_req_ack_o   = ic_ack;
  assign dc_req_ack_o   = dc_ack;
  assign ic_resp_vld_o  = ic_rvld;
  assign dc_resp_vld_o  = dc_rvld;
  assign ic_resp_data_o = l2resp_data_i;
  assign dc_resp_data_o = l2resp_data_i;
  assign l2req_vld_o    = l2_vld;
  assign l2req_rd_o     = rd_q;
  assign l2req_addr_o   = addr_q & LINE_MASK;
  assign l2req_wdata_o  = wdata_q;

endmodule : l2_req_arbiter
